// File: rtl/game_pkg.sv
// Shared state codes, command bundle and defaults for the game sequencing controller.
package game_pkg;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SEQ    = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_RESULT = 3'd6;

  // 10 ms of stable button level at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } cmd_t;

  // Moore decode: commands depend on the registered state only; code 7 drives nothing.
  function automatic cmd_t decode_cmd(input logic [2:0] st);
    cmd_t c;
    c = '0;
    case (st)
      ST_INIT:   begin c.r1 = 1'b1; c.r2 = 1'b1; end
      ST_SETUP:  c.e1 = 1'b1;
      ST_SEQ:    begin c.e3 = 1'b1; c.r2 = 1'b1; end
      ST_PLAY:   c.e2 = 1'b1;
      ST_NEXT:   begin c.e4 = 1'b1; c.r2 = 1'b1; end
      ST_RESULT: c.sel = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Enter-button conditioning: 2-flop synchronizer, optional debounce, falling-edge pulse.
// Debounce is built only when GAME_CTRL_DEBOUNCE_EN is defined.
module btn_sync_edge
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic btn_n,
  output logic pulse
);

  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic pulse_q, pulse_d;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized level differs from the accepted one;
  // a return to the accepted level clears the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb level_d = sync2_q;
`endif

  always_comb pulse_d = level_q & ~level_d;

  assign pulse = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Moore sequencing FSM for the memory game datapath; button conditioning in btn_sync_edge.
// Optional enter-button debounce enabled by defining GAME_CTRL_DEBOUNCE_EN.
//
// state  | meaning
// INIT   | clear setup, round, points, timers
// SETUP  | load setup from switches, wait for enter
// SEQ    | FPGA plays back the sequence
// PLAY   | time runs, player enters the sequence
// CHECK  | one idle cycle while match/win settle
// NEXT   | advance round and update points
// RESULT | show result, wait for enter
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       enter_n,
  input  logic       end_fpga,
  input  logic       end_user,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       r1,
  output logic       r2,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       e4,
  output logic       sel,
  output logic [2:0] state_o
);

  logic [2:0] state_q, state_d;
  logic       enter_pulse;
  cmd_t       cmd;

  btn_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock_50(clock_50),
    .reset_n (reset_n),
    .btn_n   (enter_n),
    .pulse   (enter_pulse)
  );

  // Pulses outside SETUP/RESULT fall through unused, so nothing is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_SETUP;
      ST_SETUP:  if (enter_pulse) state_d = ST_SEQ;
      ST_SEQ:    if (end_fpga) state_d = ST_PLAY;
      ST_PLAY: begin
        if (end_time) begin
          state_d = ST_RESULT;
        end else if (end_user) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK:  state_d = (match && !win) ? ST_NEXT : ST_RESULT;
      ST_NEXT:   state_d = ST_SEQ;
      ST_RESULT: if (enter_pulse) state_d = ST_INIT;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign cmd     = decode_cmd(state_q);
  assign r1      = cmd.r1;
  assign r2      = cmd.r2;
  assign e1      = cmd.e1;
  assign e2      = cmd.e2;
  assign e3      = cmd.e3;
  assign e4      = cmd.e4;
  assign sel     = cmd.sel;
  assign state_o = state_q;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the enter-button stable-time count (10 ms at 50 MHz).
REQ-002 clock_50  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 enter_n  in  1  SHALL be the raw, unsynchronized, active-low player button (board KEY[1]).
REQ-005 end_fpga, end_user, end_time, win, match  in  1 each  SHALL be datapath status flags, synchronous to clock_50.
REQ-006 r1, r2, e1, e2, e3, e4, sel  out  1 each  SHALL be datapath commands:
- r1: clear setup/round/points.
- r2: clear time counter and user-entry counter.
- e1: load setup from switches.
- e2: run time counter and accept user entries.
- e3: run FPGA sequence playback.
- e4: advance round and update points.
- sel: 0 = game display, 1 = result display.
REQ-007 state_o  out  3  SHALL expose the current state code.

Function
REQ-010 A Moore FSM SHALL be used; every command output SHALL be decoded only from the registered state, never from inputs.
REQ-011 States and encodings SHALL be INIT=0, SETUP=1, SEQ=2, PLAY=3, CHECK=4, NEXT=5, RESULT=6.
REQ-012 INIT SHALL drive r1=1, r2=1 and SHALL go to SETUP unconditionally on the next cycle.
REQ-013 SETUP SHALL drive e1=1 and SHALL go to SEQ on an enter pulse; otherwise it SHALL stay.
REQ-014 SEQ SHALL drive e3=1, r2=1 and SHALL go to PLAY when end_fpga=1.
REQ-015 PLAY SHALL drive e2=1; end_time=1 SHALL go to RESULT, else end_user=1 SHALL go to CHECK; end_time SHALL have priority when both are set.
REQ-016 CHECK SHALL drive no commands for exactly one cycle, then:
- match=0 -> RESULT.
- match=1, win=1 -> RESULT.
- match=1, win=0 -> NEXT.
REQ-017 NEXT SHALL drive e4=1, r2=1 for exactly one cycle, then SHALL go to SEQ.
REQ-018 RESULT SHALL drive sel=1 and SHALL go to INIT on an enter pulse.
REQ-019 Unlisted commands SHALL be 0 in each state; sel SHALL be 0 outside RESULT.
REQ-020 Encoding 7 SHALL go to INIT on the next cycle with all commands 0.
REQ-021 enter_n SHALL pass a 2-flop synchronizer; an enter pulse SHALL be a single-cycle high on the synchronized 1->0 transition.
REQ-022 Without debounce, the enter pulse SHALL occur 3 cycles after enter_n falls; a held button SHALL yield exactly one pulse.
REQ-023 An enter pulse arriving in any state other than SETUP/RESULT SHALL be discarded, not queued.

Reset
REQ-030 While reset_n=0:
- state SHALL be INIT (r1=r2=1, all other commands 0, state_o=0).
- synchronizer flops SHALL be 1 (released).
- the debounce counter SHALL be 0.
REQ-031 Reset asserted mid-game SHALL take effect immediately, without waiting for a clock; the first edge after release SHALL move to SETUP.

Configuration
REQ-040 With macro GAME_CTRL_DEBOUNCE_EN defined, the synchronized level SHALL be accepted only after it stays unchanged for DEBOUNCE_CYCLES consecutive cycles; any change SHALL restart the count from 0.
REQ-041 Without GAME_CTRL_DEBOUNCE_EN, no counter SHALL be synthesized and REQ-022 timing SHALL apply.

Structure
REQ-050 Shared package game_pkg SHALL hold the state encodings and the DEBOUNCE_CYCLES default.
REQ-051 Synchronizer, optional debounce and edge detect SHALL be in sub-module btn_sync_edge (in: clock_50, reset_n, btn_n; out: pulse).
REQ-052 Target size SHALL be 150-250 RTL lines total.

Verification
REQ-060 Reset release, enter_n held 1 for 20 cycles -> state_o INIT(1 cycle)->SETUP, e1=1, stays SETUP.
REQ-061 Macro off: enter_n low at cycle 10 -> pulse at cycle 13; SEQ with e3=r2=1; end_fpga=1 -> PLAY, e2=1.
REQ-062 PLAY with end_time=1 and end_user=1 together -> RESULT, sel=1; enter press -> INIT, r1=r2=1.
REQ-063 end_user=1, match=1, win=0 -> CHECK (1 cycle) -> NEXT (e4=r2=1 for 1 cycle) -> SEQ; then match=1, win=1 -> RESULT.
REQ-064 Macro on, DEBOUNCE_CYCLES=8: 3-cycle glitch -> no pulse; 10-cycle low -> one pulse; enter in PLAY -> no state change.
REQ-065 reset_n low mid-PLAY -> state_o=0 asynchronously, before the next clock edge.
